// File: rtl/ppu_reg_pkg.sv
// Shared types and constants for the PPU CPU-side register controller.
package ppu_reg_pkg;

  localparam int              VRAM_ADDR_W  = 14;
  localparam logic [13:0]     PALETTE_BASE = 14'h3F00;

  typedef enum logic [2:0] {
    PPUCTRL   = 3'd0,
    PPUMASK   = 3'd1,
    PPUSTATUS = 3'd2,
    OAMADDR   = 3'd3,
    OAMDATA   = 3'd4,
    PPUSCROLL = 3'd5,
    PPUADDR   = 3'd6,
    PPUDATA   = 3'd7
  } reg_idx_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VRAM_RD = 2'd1,
    VRAM_WR = 2'd2
  } state_e;

endpackage

// File: rtl/ppu_vram_addr_counter.sv
// VRAM address v with the two-write PPUADDR load (high byte staged in t_hi)
// and the +1/+32 post-access increment, wrapping modulo 2^14.
module ppu_vram_addr_counter
  import ppu_reg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_hi,
  input  logic                   load_lo,
  input  logic [7:0]             data,
  input  logic                   inc,
  input  logic                   inc32,
  output logic [VRAM_ADDR_W-1:0] v
);

  logic [5:0] t_hi;

  // Loads only happen in IDLE and increments only on an ack, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_hi <= '0;
      v    <= '0;
    end else begin
      if (load_hi) t_hi <= data[5:0];
      if (load_lo)  v <= {t_hi, data};
      else if (inc) v <= v + (inc32 ? 14'd32 : 14'd1);
    end
  end

endmodule

// File: rtl/ppu_reg_ctrl.sv
// PPU CPU register decode, shared write toggle and PPUDATA VRAM sequencing.
// Optional macro PPU_PALETTE_READ_BYPASS_EN: unbuffered palette reads.
module ppu_reg_ctrl
  import ppu_reg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_cs,
  input  logic                   cpu_rw,
  input  logic [2:0]             cpu_addr,
  input  logic [7:0]             cpu_data_in,
  output logic [7:0]             cpu_data_out,
  output logic                   cpu_ready,
  output logic                   cpu_busy,
  output logic [7:0]             reg_data,
  output logic                   ctrl_write_en,
  output logic                   mask_write_en,
  output logic                   oam_addr_write_en,
  output logic                   oam_data_write_en,
  output logic                   scroll_write_en,
  output logic                   write_toggle,
  input  logic                   addr_inc32,
  input  logic [2:0]             status_in,
  output logic                   status_read_strobe,
  input  logic [7:0]             oam_rdata,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic                   vram_req,
  output logic                   vram_we,
  output logic [7:0]             vram_wdata,
  input  logic [7:0]             vram_rdata,
  input  logic                   vram_ack
);

  state_e     state, state_n;
  reg_idx_e   idx;
  logic       accept, wr, rd, ack_ok, pal_hit, pal_rd;
  logic       toggle;
  logic [7:0] open_bus, buffer;

  assign idx      = reg_idx_e'(cpu_addr);
  assign accept   = cpu_cs && (state == IDLE);
  assign wr       = accept && !cpu_rw;
  assign rd       = accept && cpu_rw;
  assign ack_ok   = vram_req && vram_ack && (state != IDLE);
  assign cpu_busy = vram_req;

`ifdef PPU_PALETTE_READ_BYPASS_EN
  assign pal_hit = rd && (idx == PPUDATA) && (vram_addr >= PALETTE_BASE);
`else
  assign pal_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:             if (accept && idx == PPUDATA) state_n = cpu_rw ? VRAM_RD : VRAM_WR;
      VRAM_RD, VRAM_WR: if (ack_ok) state_n = IDLE;
      default:          state_n = IDLE;
    endcase
  end

  // toggle is the live latch used for decode; write_toggle lags it by a cycle
  // so the register blocks see the pre-access value alongside the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_out       <= '0;
      cpu_ready          <= 1'b0;
      reg_data           <= '0;
      ctrl_write_en      <= 1'b0;
      mask_write_en      <= 1'b0;
      oam_addr_write_en  <= 1'b0;
      oam_data_write_en  <= 1'b0;
      scroll_write_en    <= 1'b0;
      status_read_strobe <= 1'b0;
      write_toggle       <= 1'b0;
      toggle             <= 1'b0;
      open_bus           <= '0;
      buffer             <= '0;
      pal_rd             <= 1'b0;
      vram_req           <= 1'b0;
      vram_we            <= 1'b0;
      vram_wdata         <= '0;
    end else begin
      cpu_ready          <= accept && !pal_hit;
      ctrl_write_en      <= wr && (idx == PPUCTRL);
      mask_write_en      <= wr && (idx == PPUMASK);
      oam_addr_write_en  <= wr && (idx == OAMADDR);
      oam_data_write_en  <= wr && (idx == OAMDATA);
      scroll_write_en    <= wr && (idx == PPUSCROLL);
      status_read_strobe <= rd && (idx == PPUSTATUS);
      write_toggle       <= toggle;
      if (wr) begin
        open_bus <= cpu_data_in;
        reg_data <= cpu_data_in;
        if (idx == PPUSCROLL || idx == PPUADDR) toggle <= ~toggle;
        if (idx == PPUDATA) begin
          vram_req   <= 1'b1;
          vram_we    <= 1'b1;
          vram_wdata <= cpu_data_in;
        end
      end
      if (rd) begin
        case (idx)
          PPUSTATUS: begin
            cpu_data_out <= {status_in, open_bus[4:0]};
            toggle       <= 1'b0;
          end
          OAMDATA: cpu_data_out <= oam_rdata;
          PPUDATA: begin
            cpu_data_out <= buffer;
            vram_req     <= 1'b1;
            vram_we      <= 1'b0;
            pal_rd       <= pal_hit;
          end
          default: cpu_data_out <= open_bus;
        endcase
      end
      if (ack_ok) begin
        vram_req <= 1'b0;
        vram_we  <= 1'b0;
        pal_rd   <= 1'b0;
        if (state == VRAM_RD) buffer <= vram_rdata;
        if (pal_rd) begin
          cpu_ready    <= 1'b1;
          cpu_data_out <= vram_rdata;
        end
      end
    end
  end

  ppu_vram_addr_counter u_addr (
    .clk     (clk),
    .rst     (rst),
    .load_hi (wr && (idx == PPUADDR) && !toggle),
    .load_lo (wr && (idx == PPUADDR) && toggle),
    .data    (cpu_data_in),
    .inc     (ack_ok),
    .inc32   (addr_inc32),
    .v       (vram_addr)
  );

endmodule

// File: tb/tb_ppu_reg_ctrl.sv
// Directed self-checking bench for ppu_reg_ctrl (default and palette-bypass builds).
module tb_ppu_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_rw;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_data_in, cpu_data_out;
  logic        cpu_ready, cpu_busy;
  logic [7:0]  reg_data;
  logic        ctrl_write_en, mask_write_en, oam_addr_write_en, oam_data_write_en, scroll_write_en;
  logic        write_toggle, addr_inc32, status_read_strobe;
  logic [2:0]  status_in;
  logic [7:0]  oam_rdata;
  logic [13:0] vram_addr;
  logic        vram_req, vram_we, vram_ack;
  logic [7:0]  vram_wdata, vram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ppu_reg_ctrl dut (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .cpu_busy(cpu_busy), .reg_data(reg_data), .ctrl_write_en(ctrl_write_en),
    .mask_write_en(mask_write_en), .oam_addr_write_en(oam_addr_write_en),
    .oam_data_write_en(oam_data_write_en), .scroll_write_en(scroll_write_en),
    .write_toggle(write_toggle), .addr_inc32(addr_inc32), .status_in(status_in),
    .status_read_strobe(status_read_strobe), .oam_rdata(oam_rdata),
    .vram_addr(vram_addr), .vram_req(vram_req), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack)
  );

  // One-cycle access; returns in the middle of cycle N+1.
  task automatic access(input logic rw, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_data_in = d;
    @(negedge clk);
    cpu_cs = 1'b0;
  endtask

  // Ack after n further cycles; returns in the cycle after the ack.
  task automatic do_ack(input int n);
    repeat (n) @(negedge clk);
    vram_ack = 1'b1;
    @(negedge clk);
    vram_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_cs = 0; cpu_rw = 0; cpu_addr = 0; cpu_data_in = 0;
    addr_inc32 = 0; status_in = 0; oam_rdata = 0; vram_rdata = 0; vram_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (vram_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", vram_req); end
    n_cmp++; if (vram_addr !== 14'h0) begin n_bad++; $display("FAIL reset_v: got %h want 0000", vram_addr); end
    n_cmp++; if (write_toggle !== 1'b0) begin n_bad++; $display("FAIL reset_toggle: got %b want 0", write_toggle); end
    n_cmp++; if (cpu_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", cpu_data_out); end
  endtask

  task automatic test_scroll;
    access(0, 3'd5, 8'h12);
    n_cmp++; if ({scroll_write_en, reg_data, write_toggle, cpu_ready} !== {1'b1, 8'h12, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL scroll_1: got en=%b data=%h tog=%b rdy=%b want 1 12 0 1", scroll_write_en, reg_data, write_toggle, cpu_ready); end
    access(0, 3'd5, 8'h34);
    n_cmp++; if ({scroll_write_en, reg_data, write_toggle} !== {1'b1, 8'h34, 1'b1}) begin
      n_bad++; $display("FAIL scroll_2: got en=%b data=%h tog=%b want 1 34 1", scroll_write_en, reg_data, write_toggle); end
    @(negedge clk);
    n_cmp++; if ({scroll_write_en, write_toggle} !== 2'b00) begin
      n_bad++; $display("FAIL scroll_after: got en=%b tog=%b want 0 0", scroll_write_en, write_toggle); end
  endtask

  task automatic test_decode;
    logic [2:0] idxs [4];
    logic [4:0] exp_en [4];
    idxs = '{3'd0, 3'd1, 3'd3, 3'd4};
    exp_en = '{5'b10000, 5'b01000, 5'b00100, 5'b00010};
    for (int i = 0; i < 4; i++) begin
      access(0, idxs[i], 8'h40 + 8'(i));
      n_cmp++; if ({ctrl_write_en, mask_write_en, oam_addr_write_en, oam_data_write_en, scroll_write_en} !== exp_en[i]) begin
        n_bad++; $display("FAIL decode_%0d: got %b want %b", idxs[i],
          {ctrl_write_en, mask_write_en, oam_addr_write_en, oam_data_write_en, scroll_write_en}, exp_en[i]); end
    end
    access(0, 3'd2, 8'h9C);
    n_cmp++; if ({ctrl_write_en, mask_write_en, oam_addr_write_en, oam_data_write_en, scroll_write_en, cpu_ready} !== 6'b000001) begin
      n_bad++; $display("FAIL decode_status_wr: got ens=%b rdy=%b want 00000 1",
        {ctrl_write_en, mask_write_en, oam_addr_write_en, oam_data_write_en, scroll_write_en}, cpu_ready); end
    access(1, 3'd0, 8'h00);
    n_cmp++; if (cpu_data_out !== 8'h9C) begin n_bad++; $display("FAIL openbus_rd: got %h want 9c", cpu_data_out); end
    oam_rdata = 8'h77;
    access(1, 3'd4, 8'h00);
    n_cmp++; if (cpu_data_out !== 8'h77) begin n_bad++; $display("FAIL oamdata_rd: got %h want 77", cpu_data_out); end
  endtask

  task automatic test_vram_write;
    access(0, 3'd6, 8'h21);
    access(0, 3'd6, 8'h08);
    n_cmp++; if (vram_addr !== 14'h2108) begin n_bad++; $display("FAIL addr_load: got %h want 2108", vram_addr); end
    access(0, 3'd7, 8'hAA);
    n_cmp++; if ({vram_req, vram_we, vram_wdata, cpu_busy, cpu_ready} !== {1'b1, 1'b1, 8'hAA, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL vwr_req: got req=%b we=%b wd=%h busy=%b rdy=%b want 1 1 aa 1 1",
        vram_req, vram_we, vram_wdata, cpu_busy, cpu_ready); end
    // A strobe while busy is ignored entirely.
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd0; cpu_data_in = 8'hEE;
    @(negedge clk);
    cpu_cs = 1'b0;
    n_cmp++; if ({ctrl_write_en, cpu_ready, vram_req} !== 3'b001) begin
      n_bad++; $display("FAIL busy_ignore: got en=%b rdy=%b req=%b want 0 0 1", ctrl_write_en, cpu_ready, vram_req); end
    do_ack(0);
    n_cmp++; if ({vram_req, cpu_busy, vram_addr} !== {1'b0, 1'b0, 14'h2109}) begin
      n_bad++; $display("FAIL vwr_done: got req=%b busy=%b v=%h want 0 0 2109", vram_req, cpu_busy, vram_addr); end
  endtask

  task automatic test_vram_read;
    access(0, 3'd6, 8'h20);
    access(0, 3'd6, 8'h00);
    vram_rdata = 8'h5A;
    access(1, 3'd7, 8'h00);
    n_cmp++; if ({cpu_data_out, cpu_ready, vram_req, vram_we} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL vrd_1: got d=%h rdy=%b req=%b we=%b want 00 1 1 0", cpu_data_out, cpu_ready, vram_req, vram_we); end
    do_ack(0);
    n_cmp++; if (vram_addr !== 14'h2001) begin n_bad++; $display("FAIL vrd_inc1: got %h want 2001", vram_addr); end
    access(1, 3'd7, 8'h00);
    n_cmp++; if (cpu_data_out !== 8'h5A) begin n_bad++; $display("FAIL vrd_2: got %h want 5a", cpu_data_out); end
    do_ack(1);
    n_cmp++; if ({vram_req, vram_addr} !== {1'b0, 14'h2002}) begin
      n_bad++; $display("FAIL vrd_inc2: got req=%b v=%h want 0 2002", vram_req, vram_addr); end
  endtask

  task automatic test_wrap;
    access(0, 3'd6, 8'h3F);
    access(0, 3'd6, 8'hF0);
    addr_inc32 = 1'b1;
    access(0, 3'd7, 8'h55);
    do_ack(0);
    addr_inc32 = 1'b0;
    n_cmp++; if (vram_addr !== 14'h0010) begin n_bad++; $display("FAIL wrap32: got %h want 0010", vram_addr); end
  endtask

  task automatic test_status;
    access(0, 3'd6, 8'h21);
    @(negedge clk);
    n_cmp++; if (write_toggle !== 1'b1) begin n_bad++; $display("FAIL status_pre_tog: got %b want 1", write_toggle); end
    status_in = 3'b100;
    access(1, 3'd2, 8'h00);
    n_cmp++; if ({cpu_data_out, status_read_strobe, write_toggle} !== {8'h81, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL status_rd: got d=%h strb=%b tog=%b want 81 1 1", cpu_data_out, status_read_strobe, write_toggle); end
    @(negedge clk);
    n_cmp++; if ({status_read_strobe, write_toggle} !== 2'b00) begin
      n_bad++; $display("FAIL status_clr: got strb=%b tog=%b want 0 0", status_read_strobe, write_toggle); end
    status_in = 3'b000;
    access(0, 3'd6, 8'h3A);
    access(0, 3'd6, 8'h44);
    n_cmp++; if (vram_addr !== 14'h3A44) begin n_bad++; $display("FAIL status_first_wr: got %h want 3a44", vram_addr); end
  endtask

  task automatic test_reset_mid;
    access(1, 3'd7, 8'h00);
    n_cmp++; if (vram_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req: got %b want 1", vram_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({vram_req, cpu_busy, vram_addr} !== {1'b0, 1'b0, 14'h0}) begin
      n_bad++; $display("FAIL rmid_drop: got req=%b busy=%b v=%h want 0 0 0000", vram_req, cpu_busy, vram_addr); end
    vram_rdata = 8'hC3;
    do_ack(0);
    n_cmp++; if ({vram_req, cpu_ready, vram_addr} !== {1'b0, 1'b0, 14'h0}) begin
      n_bad++; $display("FAIL rmid_late_ack: got req=%b rdy=%b v=%h want 0 0 0000", vram_req, cpu_ready, vram_addr); end
  endtask

  task automatic test_palette;
    access(0, 3'd6, 8'h3F);
    access(0, 3'd6, 8'h01);
    vram_rdata = 8'h0F;
    access(1, 3'd7, 8'h00);
`ifdef PPU_PALETTE_READ_BYPASS_EN
    n_cmp++; if ({cpu_ready, vram_req} !== 2'b01) begin
      n_bad++; $display("FAIL pal_withheld: got rdy=%b req=%b want 0 1", cpu_ready, vram_req); end
    do_ack(0);
    n_cmp++; if ({cpu_ready, cpu_data_out, vram_addr} !== {1'b1, 8'h0F, 14'h3F02}) begin
      n_bad++; $display("FAIL pal_bypass: got rdy=%b d=%h v=%h want 1 0f 3f02", cpu_ready, cpu_data_out, vram_addr); end
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL pal_ready_pulse: got %b want 0", cpu_ready); end
`else
    n_cmp++; if ({cpu_ready, cpu_data_out} !== {1'b1, 8'h00}) begin
      n_bad++; $display("FAIL pal_buffered: got rdy=%b d=%h want 1 00", cpu_ready, cpu_data_out); end
    do_ack(0);
    n_cmp++; if ({cpu_ready, vram_addr} !== {1'b0, 14'h3F02}) begin
      n_bad++; $display("FAIL pal_no_extra_ready: got rdy=%b v=%h want 0 3f02", cpu_ready, vram_addr); end
`endif
    access(0, 3'd6, 8'h20);
    access(0, 3'd6, 8'h00);
    access(1, 3'd7, 8'h00);
    n_cmp++; if (cpu_data_out !== 8'h0F) begin n_bad++; $display("FAIL pal_buf_loaded: got %h want 0f", cpu_data_out); end
    do_ack(0);
  endtask

  initial begin
    test_reset;
    test_scroll;
    test_decode;
    test_vram_write;
    test_vram_read;
    test_wrap;
    test_status;
    test_reset_mid;
    test_palette;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
